// File: rtl/conv3x3_seq_drain_if.sv
// ---------------------------------------------------------------------------
// conv3x3_seq_drain_if
// Groups the window handshake, the MAC control/result lines and the int8
// result stream of conv3x3_seq_drain.
//   win_valid  upstream window + weights present and held stable
//   win_ready  window consumed (one-cycle pop pulse)
//   cnt        tap index to the MAC (0..8 taps, 9 capture/hold, 10 idle)
//   ans        signed 21-bit MAC accumulator
//   bias       signed 21-bit bias, sampled in the push cycle
//   out_data   signed int8 result at the FIFO head (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  downstream accept
//   fifo_cnt   FIFO occupancy
// Modport master is the drain block, slave is its environment.
// ---------------------------------------------------------------------------
interface conv3x3_seq_drain_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                win_valid;
    logic                win_ready;
    logic [3:0]          cnt;
    logic signed [20:0]  ans;
    logic signed [20:0]  bias;
    logic signed [7:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic [CW-1:0]       fifo_cnt;

    modport master (
        input  win_valid, ans, bias, out_ready,
        output win_ready, cnt, out_data, out_valid, fifo_cnt
    );

    modport slave (
        output win_valid, ans, bias, out_ready,
        input  win_ready, cnt, out_data, out_valid, fifo_cnt
    );
endinterface

// File: rtl/conv3x3_seq_drain.sv
// ---------------------------------------------------------------------------
// conv3x3_seq_drain
// Control-and-result end of a time-multiplexed 3x3 MAC. Sequences the MAC tap
// counter, pops one window per pass, captures the 9-tap sum, adds a bias,
// requantizes to int8 (round half up, arithmetic shift, optional ReLU,
// saturate) and queues results in a small FIFO.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    conv3x3_seq_drain_if.master (window handshake, cnt, ans, bias,
//          int8 output stream, fifo_cnt)
// Parameters:
//   SHIFT  right shift after bias add (0..16)
//   RELU   1: negative results clamp to 0 before saturation
//   DEPTH  FIFO entries (power of 2, >= 2)
// ---------------------------------------------------------------------------
module conv3x3_seq_drain #(
    parameter int SHIFT = 8,
    parameter bit RELU  = 1'b0,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv3x3_seq_drain_if.master    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [22:0] RND = (SHIFT > 0) ? (23'sd1 <<< RND_BIT) : 23'sd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CAP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_tap;
    logic [3:0]          w_tap_nxt;

    logic [7:0]          r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;

    logic signed [22:0]  w_sum;
    logic signed [22:0]  w_rnd;
    logic signed [22:0]  w_act;
    logic signed [7:0]   w_q;

    // ------------------------------------------------------------------
    // Pass sequencer. The external cnt encoding (0..8 / 9 / 10) is
    // rebuilt from a three-state FSM plus a tap index.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tap   <= w_tap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tap_nxt   = r_tap;
        case (r_state)
            S_IDLE: begin
                if (bus.win_valid) begin
                    w_state_nxt = S_RUN;
                    w_tap_nxt   = '0;
                end
            end
            S_RUN: begin
                // win_valid is not re-checked while taps are streaming
                if (r_tap == 4'd8) begin
                    w_state_nxt = S_CAP;
                end else begin
                    w_tap_nxt = r_tap + 4'd1;
                end
            end
            S_CAP: begin
                // without a push the pass stalls here; the MAC adds 0 so ans holds
                if (w_push) begin
                    w_tap_nxt   = '0;
                    w_state_nxt = bus.win_valid ? S_RUN : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tap_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        case (r_state)
            S_RUN:   bus.cnt = r_tap;
            S_CAP:   bus.cnt = 4'd9;
            default: bus.cnt = 4'd10;
        endcase
    end

    assign bus.win_ready = (r_state == S_RUN) && (r_tap == 4'd8);

    // ------------------------------------------------------------------
    // Requantization. One guard bit above the 22-bit sum keeps the
    // rounding add from wrapping at the positive extreme.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum = {{2{bus.ans[20]}}, bus.ans} + {{2{bus.bias[20]}}, bus.bias};
        w_rnd = (w_sum + RND) >>> SHIFT;
        w_act = (RELU && (w_rnd < 23'sd0)) ? 23'sd0 : w_rnd;
        if (w_act > 23'sd127) begin
            w_q = 8'sd127;
        end else if (w_act < -23'sd128) begin
            w_q = -8'sd128;
        end else begin
            w_q = w_act[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. A pop frees a slot in the same cycle, so a full FIFO
    // can accept a push while popping.
    // ------------------------------------------------------------------
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_push  = (r_state == S_CAP) && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_q;
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rptr];
    assign bus.fifo_cnt  = r_count;

endmodule
